bist_ctrl_multiseed: RTL and testbench
======================================

// Module: bist_ctrl_multiseed
// PURPOSE
//  Parametrised successor BIST controller: sequences LFSR/MISR test sessions of M_BLK blocks x N_CYC cycles.
//  Drives run-enable, seed-bank index, seed-load and polynomial select to the pattern generator.
//  Compares the final MISR signature against a golden value and reports PASS.
//  Supports ABORT and re-arm on a fresh START rising edge; sits between top-level test control and LFSR/MISR.
// PARAMETERS
//  CNT_W       7      width of cnt_n and cnt_m
//  N_CYC       9      cycles per block (>=2, < 2**CNT_W)
//  M_BLK       110    blocks per session (>=NUM_SEEDS, < 2**CNT_W)
//  NUM_SEEDS   4      seed segments per session (power of 2)
//  SEED_W      2      log2(NUM_SEEDS), min 1
//  POLY_SWITCH 55     block index from which POLY_SEL=1
//  SIG_W       16     MISR signature width
//  GOLDEN_SIG  16'h0  expected signature
// PORTS
//  CLK        in   1       clock, all logic on rising edge
//  RESET      in   1       synchronous, active-high reset
//  START      in   1       session request; level, rising edge required
//  ABORT      in   1       terminate running session
//  MISR_SIG   in   SIG_W   signature from compactor, stable in DONE
//  INIT       out  1       1-cycle pulse: clear LFSR/MISR before run
//  OUT        out  1       run enable to LFSR/MISR/CUT
//  SEED_LOAD  out  1       1-cycle pulse: load seed SEED_SEL
//  SEED_SEL   out  SEED_W  active seed bank index
//  POLY_SEL   out  1       polynomial select
//  BIST_END   out  1       session ended, result valid
//  FINISH     out  1       1-cycle pulse on session end
//  PASS       out  1       registered result, valid while BIST_END=1
// BEHAVIOUR
//  - Reset: state=IDLE, cnt_n=cnt_m=0, PASS=0, aborted=0; all outputs 0. Reset mid-session wins over every input.
//  - States: IDLE, ARM, INIT, RUN, DONE, HOLD, REARM. Outputs decoded from state and counters; PASS registered.
//  - IDLE: START=0 -> ARM, else stay. A START held high out of reset never launches a session.
//  - ARM: START=1 -> INIT. INIT: INIT=1, counters cleared, PASS<=0, aborted<=0 -> RUN next cycle.
//    Latency from START sampled high in ARM to first OUT=1 cycle: 2 cycles.
//  - RUN: OUT=1. cnt_n++ each cycle. At cnt_n==N_CYC-1: cnt_n<=0, cnt_m++.
//    At cnt_m==M_BLK-1 and cnt_n==N_CYC-1 -> DONE. Exactly N_CYC*M_BLK cycles with OUT=1.
//  - SEG = M_BLK/NUM_SEEDS (integer). SEED_SEL = min(cnt_m/SEG, NUM_SEEDS-1). Remainder blocks stay on the last seed.
//  - SEED_LOAD=1 in RUN when cnt_n==0 and cnt_m%SEG==0 and cnt_m/SEG<NUM_SEEDS. First pulse at RUN cycle 0.
//  - POLY_SEL = (state==RUN) && (cnt_m>=POLY_SWITCH). 0 outside RUN.
//  - ABORT=1 in RUN -> DONE next cycle and aborted<=1. ABORT ignored in all other states.
//    ABORT on the final RUN cycle: ABORT wins, aborted=1.
//  - DONE (1 cycle): FINISH=1, BIST_END=1, PASS<=(!aborted && MISR_SIG==GOLDEN_SIG) -> HOLD.
//  - HOLD: BIST_END=1; START=0 -> REARM. REARM: BIST_END=1; START=1 -> INIT (PASS cleared in INIT).
//  - PASS holds its value from DONE until the next INIT or RESET.
//  - START changes during INIT/RUN: ignored.
//  - Counters never exceed their terminal values. No wrap on 2**CNT_W.
//  - Illegal state -> IDLE next cycle, outputs 0.
// STRUCTURE
//  - Shared package bist_pkg: state encoding localparams, default N_CYC/M_BLK/NUM_SEEDS,
//    function clog2 for SEED_W checks.
//  - Sub-module bist_blk_counter (CNT_W, N_CYC, M_BLK):
//    en/clr in; cnt_n, cnt_m, blk_wrap, last out.
//  - FSM, seed/poly decode and result register stay in the top module.
//  - Elaboration-time check: M_BLK>=NUM_SEEDS, POLY_SWITCH<M_BLK.
// TESTING (N_CYC=3, M_BLK=8, NUM_SEEDS=4, POLY_SWITCH=4, GOLDEN_SIG=16'hBEEF)
//  - Reset with START=1, then START held 1 -> stays IDLE; START 0->1 -> INIT pulse 1 cycle later,
//    then OUT=1 for exactly 24 cycles.
//  - Full run -> SEED_LOAD pulses at RUN cycles 0,6,12,18 with SEED_SEL 0,1,2,3;
//    POLY_SEL rises at RUN cycle 12.
//  - MISR_SIG=16'hBEEF in DONE -> FINISH pulse 1 cycle, BIST_END=1, PASS=1;
//    MISR_SIG=16'hBEEE -> PASS=0.
//  - ABORT=1 at RUN cycle 10 -> OUT=0, DONE next cycle, FINISH pulse, PASS=0 even with matching signature.
//  - HOLD with START held 1 -> no restart; START 0 then 1 -> INIT, PASS cleared to 0, new 24-cycle run.
//  - RESET asserted at RUN cycle 7 -> next cycle IDLE, all outputs 0, counters 0.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared definitions for the multi-seed BIST controller: state encoding,
// default session geometry and a ceiling-log2 helper for parameter checks.
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_INIT  = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_HOLD  = 3'd5,
    S_REARM = 3'd6
  } state_t;

  localparam int DEF_N_CYC     = 9;
  localparam int DEF_M_BLK     = 110;
  localparam int DEF_NUM_SEEDS = 4;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bist_blk_counter.sv
// Two-level session counter: cnt_n counts cycles inside a block, cnt_m counts
// blocks. Both saturate at their terminal values so they never wrap.
module bist_blk_counter #(
  parameter int CNT_W = 7,
  parameter int N_CYC = 9,
  parameter int M_BLK = 110
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt_n,
  output logic [CNT_W-1:0] cnt_m,
  output logic             blk_wrap,
  output logic             last
);

  localparam logic [CNT_W-1:0] N_LAST = CNT_W'(N_CYC - 1);
  localparam logic [CNT_W-1:0] M_LAST = CNT_W'(M_BLK - 1);

  // blk_wrap: final cycle of the current block; last: currently in the final block.
  assign blk_wrap = (cnt_n == N_LAST);
  assign last     = (cnt_m == M_LAST);

  // Count while enabled; hold once the final cycle of the final block is reached.
  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      cnt_n <= '0;
      cnt_m <= '0;
    end else if (en && !(blk_wrap && last)) begin
      if (blk_wrap) begin
        cnt_n <= '0;
        cnt_m <= cnt_m + 1'b1;
      end else begin
        cnt_n <= cnt_n + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bist_ctrl_multiseed.sv
// Multi-seed BIST session controller. Sequences M_BLK x N_CYC run cycles,
// steps through NUM_SEEDS seed banks, switches polynomial at POLY_SWITCH and
// grades the final MISR signature. Handshake: START is a level whose rising
// edge (seen as 0 in IDLE/HOLD, then 1 in ARM/REARM) launches one session;
// ABORT is honoured only while running; results are valid while BIST_END=1.
module bist_ctrl_multiseed
  import bist_pkg::*;
#(
  parameter int               CNT_W       = 7,
  parameter int               N_CYC       = DEF_N_CYC,
  parameter int               M_BLK       = DEF_M_BLK,
  parameter int               NUM_SEEDS   = DEF_NUM_SEEDS,
  parameter int               SEED_W      = 2,
  parameter int               POLY_SWITCH = 55,
  parameter int               SIG_W       = 16,
  parameter logic [SIG_W-1:0] GOLDEN_SIG  = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic              ABORT,
  input  logic [SIG_W-1:0]  MISR_SIG,
  output logic              INIT,
  output logic              OUT,
  output logic              SEED_LOAD,
  output logic [SEED_W-1:0] SEED_SEL,
  output logic              POLY_SEL,
  output logic              BIST_END,
  output logic              FINISH,
  output logic              PASS,
  output logic [2:0]        STATE_DBG
);

  localparam int SEG = M_BLK / NUM_SEEDS;
  localparam logic [CNT_W-1:0] SEG_C       = CNT_W'(SEG);
  localparam logic [CNT_W-1:0] NUM_SEEDS_C = CNT_W'(NUM_SEEDS);
  localparam logic [CNT_W-1:0] LAST_SEED_C = CNT_W'(NUM_SEEDS - 1);
  localparam logic [CNT_W-1:0] POLY_C      = CNT_W'(POLY_SWITCH);
  localparam int SEED_W_EXP = (clog2(NUM_SEEDS) < 1) ? 1 : clog2(NUM_SEEDS);

  if (M_BLK < NUM_SEEDS) begin : g_bad_blk
    $error("M_BLK must be >= NUM_SEEDS");
  end
  if (POLY_SWITCH >= M_BLK) begin : g_bad_poly
    $error("POLY_SWITCH must be < M_BLK");
  end
  if (SEED_W != SEED_W_EXP) begin : g_bad_seed_w
    $error("SEED_W must equal log2(NUM_SEEDS), min 1");
  end

  state_t           state, state_nxt;
  logic             aborted;
  logic             pass_q;
  logic [CNT_W-1:0] cnt_n, cnt_m;
  logic             blk_wrap, last_blk;
  logic [CNT_W-1:0] seg_idx, seg_rem;

  assign STATE_DBG = state;

  bist_blk_counter #(
    .CNT_W (CNT_W),
    .N_CYC (N_CYC),
    .M_BLK (M_BLK)
  ) u_cnt (
    .CLK      (CLK),
    .RESET    (RESET),
    .en       (state == S_RUN),
    .clr      (state == S_INIT),
    .cnt_n    (cnt_n),
    .cnt_m    (cnt_m),
    .blk_wrap (blk_wrap),
    .last     (last_blk)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Abort flag and graded result; cleared on every new session.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      aborted <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          aborted <= 1'b0;
          pass_q  <= 1'b0;
        end
        S_RUN:  if (ABORT) aborted <= 1'b1;
        S_DONE: pass_q <= !aborted && (MISR_SIG == GOLDEN_SIG);
        default: ;
      endcase
    end
  end

  // Next-state logic; illegal encodings fall back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (!START) state_nxt = S_ARM;
      S_ARM:   if (START)  state_nxt = S_INIT;
      S_INIT:  state_nxt = S_RUN;
      S_RUN:   if (ABORT || (blk_wrap && last_blk)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_HOLD;
      S_HOLD:  if (!START) state_nxt = S_REARM;
      S_REARM: if (START)  state_nxt = S_INIT;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from state and counters; seed index saturates on the last bank.
  always_comb begin
    INIT      = 1'b0;
    OUT       = 1'b0;
    SEED_LOAD = 1'b0;
    SEED_SEL  = '0;
    POLY_SEL  = 1'b0;
    BIST_END  = 1'b0;
    FINISH    = 1'b0;
    PASS      = pass_q;
    seg_idx   = cnt_m / SEG_C;
    seg_rem   = cnt_m % SEG_C;
    case (state)
      S_IDLE, S_ARM: ;
      S_INIT: INIT = 1'b1;
      S_RUN: begin
        OUT       = 1'b1;
        SEED_SEL  = (seg_idx >= LAST_SEED_C) ? SEED_W'(NUM_SEEDS - 1)
                                             : seg_idx[SEED_W-1:0];
        SEED_LOAD = (cnt_n == '0) && (seg_rem == '0) && (seg_idx < NUM_SEEDS_C);
        POLY_SEL  = (cnt_m >= POLY_C);
      end
      S_DONE: begin
        FINISH   = 1'b1;
        BIST_END = 1'b1;
      end
      S_HOLD, S_REARM: BIST_END = 1'b1;
      default: PASS = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_bist_ctrl_multiseed.sv
// Directed bench for bist_ctrl_multiseed with a 3-cycle x 8-block session,
// four seed banks and the polynomial switch at block 4.
module tb_bist_ctrl_multiseed;
  import bist_pkg::*;

  localparam logic [15:0] GOLD = 16'hBEEF;

  logic        CLK, RESET, START, ABORT;
  logic [15:0] MISR_SIG;
  logic        INIT, OUT, SEED_LOAD, POLY_SEL, BIST_END, FINISH, PASS;
  logic [1:0]  SEED_SEL;
  logic [2:0]  STATE_DBG;

  int checks = 0;
  int errors = 0;

  // Expected {state, INIT, OUT, SEED_LOAD, SEED_SEL[1:0], POLY_SEL, BIST_END, FINISH, PASS}
  logic [11:0] exp_q[$];

  typedef struct {
    logic       rst;
    logic       start;
    logic       abort;
    logic [2:0] st;
    logic [8:0] v;
  } vec_t;

  vec_t tbl[6];

  bist_ctrl_multiseed #(
    .CNT_W       (7),
    .N_CYC       (3),
    .M_BLK       (8),
    .NUM_SEEDS   (4),
    .SEED_W      (2),
    .POLY_SWITCH (4),
    .SIG_W       (16),
    .GOLDEN_SIG  (GOLD)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .START     (START),
    .ABORT     (ABORT),
    .MISR_SIG  (MISR_SIG),
    .INIT      (INIT),
    .OUT       (OUT),
    .SEED_LOAD (SEED_LOAD),
    .SEED_SEL  (SEED_SEL),
    .POLY_SEL  (POLY_SEL),
    .BIST_END  (BIST_END),
    .FINISH    (FINISH),
    .PASS      (PASS),
    .STATE_DBG (STATE_DBG)
  );

  // Clock and watchdog.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [8:0] vec(input logic i, input logic o, input logic ld,
                                     input logic [1:0] sel, input logic poly,
                                     input logic e, input logic f, input logic p);
    return {i, o, ld, sel, poly, e, f, p};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard: queue the expectation, then compare the sampled outputs against it.
  task automatic expect_now(input string name, input logic [2:0] st, input logic [8:0] v);
    logic [11:0] exp, got;
    exp_q.push_back({st, v});
    exp = exp_q.pop_front();
    got = {STATE_DBG, INIT, OUT, SEED_LOAD, SEED_SEL, POLY_SEL, BIST_END, FINISH, PASS};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got st=%0d vec=%b exp st=%0d vec=%b",
               name, got[11:9], got[8:0], exp[11:9], exp[8:0]);
    end
  endtask

  // Drive a session that starts from the INIT cycle. abort_at/reset_at select
  // the RUN cycle at which ABORT or RESET is applied (-1 = never).
  task automatic run_session(input int abort_at, input int reset_at,
                             input logic [15:0] sig, input logic exp_pass);
    for (int c = 0; c < 24; c++) begin
      MISR_SIG = 16'($urandom_range(0, 65535));
      tick();
      expect_now($sformatf("run_c%0d", c), S_RUN,
                 vec(1'b0, 1'b1, (c % 6) == 0, 2'(c / 6), c >= 12, 1'b0, 1'b0, 1'b0));
      if (c == reset_at) begin
        RESET = 1'b1;
        tick();
        expect_now("reset_mid", S_IDLE, 9'b0);
        checks++;
        if (dut.u_cnt.cnt_n !== 7'd0 || dut.u_cnt.cnt_m !== 7'd0) begin
          errors++;
          $display("FAIL reset_cnt got n=%0d m=%0d exp n=0 m=0",
                   dut.u_cnt.cnt_n, dut.u_cnt.cnt_m);
        end
        RESET = 1'b0;
        return;
      end
      ABORT = (c == abort_at);
      if (c == abort_at) break;
    end
    MISR_SIG = sig;
    tick();
    ABORT = 1'b0;
    expect_now("done", S_DONE, vec(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    tick();
    expect_now("hold", S_HOLD, vec(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, exp_pass));
  endtask

  // From HOLD: drop START to reach REARM, raise it to reach INIT.
  task automatic rearm(input logic prev_pass);
    START = 1'b0;
    tick();
    expect_now("rearm", S_REARM, vec(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, prev_pass));
    START = 1'b1;
    tick();
    expect_now("reinit", S_INIT, vec(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, prev_pass));
  endtask

  initial begin
    RESET = 1'b1;
    START = 1'b1;
    ABORT = 1'b0;
    MISR_SIG = 16'h0;

    // Reset with START high, START held (no launch), then a clean 0->1 edge.
    tbl[0] = '{1'b1, 1'b1, 1'b0, S_IDLE, 9'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, S_IDLE, 9'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, S_IDLE, 9'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, S_ARM,  9'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, S_ARM,  9'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b0, S_INIT, vec(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0)};

    tick();
    for (int i = 0; i < 6; i++) begin
      RESET = tbl[i].rst;
      START = tbl[i].start;
      ABORT = tbl[i].abort;
      tick();
      expect_now($sformatf("tbl%0d", i), tbl[i].st, tbl[i].v);
    end
    ABORT = 1'b0;

    // Full run with matching signature.
    run_session(-1, -1, GOLD, 1'b1);

    // HOLD: START still high and ABORT pulsed -> no restart.
    ABORT = 1'b1;
    tick();
    expect_now("hold_abort", S_HOLD, vec(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1));
    ABORT = 1'b0;
    tick();
    expect_now("hold_start", S_HOLD, vec(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1));

    // Re-arm; PASS must read 0 from the first run cycle; wrong signature fails.
    rearm(1'b1);
    run_session(-1, -1, 16'hBEEE, 1'b0);

    // Abort mid-run with matching signature.
    rearm(1'b0);
    run_session(10, -1, GOLD, 1'b0);

    // Abort on the final run cycle.
    rearm(1'b0);
    run_session(23, -1, GOLD, 1'b0);

    // Good run, then reset during the following run.
    rearm(1'b0);
    run_session(-1, -1, GOLD, 1'b1);
    rearm(1'b1);
    run_session(-1, 7, GOLD, 1'b0);

    // After reset with START high, the controller must stay idle.
    tick();
    expect_now("post_reset_idle0", S_IDLE, 9'b0);
    tick();
    expect_now("post_reset_idle1", S_IDLE, 9'b0);
    START = 1'b0;
    tick();
    expect_now("post_reset_arm", S_ARM, 9'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
